hbus_arb: RTL and testbench



---
 rtl/hbus_arb.sv | 150 +++++++++++++++
 tb/tb_hbus_arb.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/hbus_arb.sv
// Shared-bus line arbiter: round-robin grants from per-hart L2 ports onto one memory
// port, AMO bus lock, and invalidate broadcast to the other harts after each write.
module hbus_arb #(
  parameter int N_HARTS = 2,
  parameter int LINE_W  = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_HARTS*64-1:0]    h_addr,
  input  logic [N_HARTS*LINE_W-1:0] h_wdata,
  input  logic [N_HARTS-1:0]       h_rd,
  input  logic [N_HARTS-1:0]       h_wr,
  output logic [N_HARTS-1:0]       h_dv,
  output logic [LINE_W-1:0]        h_rdata,
  input  logic [N_HARTS-1:0]       h_amo_req,
  output logic [N_HARTS-1:0]       h_amo_ack,
  output logic [63:0]              h_inv_addr,
  output logic [N_HARTS-1:0]       h_inv,
  output logic [63:0]              m_addr,
  output logic [LINE_W-1:0]        m_wdata,
  output logic                     m_rd,
  output logic                     m_wr,
  input  logic [LINE_W-1:0]        m_rdata,
  input  logic                     m_dv
);

  localparam int IW  = (N_HARTS > 1) ? $clog2(N_HARTS) : 1;
  localparam int OFF = $clog2(LINE_W / 8);
  localparam logic [63:0] ALIGN_MASK = ~((64'd1 << OFF) - 64'd1);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       grant_q;
  logic                is_wr_q;
  logic [63:0]         addr_q;
  logic [LINE_W-1:0]   wdata_q;
  logic [LINE_W-1:0]   rdata_q;
  logic                lock_held;
  logic [IW-1:0]       lock_owner;

  logic [N_HARTS-1:0]  elig;
  logic                found;
  logic [IW-1:0]       pick;
  logic                amo_any;
  logic [IW-1:0]       amo_pick;
  int                  idx;

  // While the lock is held only its owner may be granted the bus.
  always_comb begin
    for (int i = 0; i < N_HARTS; i++)
      elig[i] = (h_rd[i] | h_wr[i]) && (!lock_held || lock_owner == IW'(i));
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    found = 1'b0;
    pick  = grant_q;
    idx   = 0;
    for (int k = 1; k <= N_HARTS; k++) begin
      idx = (int'(grant_q) + k) % N_HARTS;
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_comb begin
    amo_any  = 1'b0;
    amo_pick = '0;
    for (int i = N_HARTS - 1; i >= 0; i--) begin
      if (h_amo_req[i]) begin
        amo_any  = 1'b1;
        amo_pick = IW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (found) state_d = h_wr[pick] ? WR : RD;
      RD, WR:  if (m_dv) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= '0;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == IDLE && found) begin
        grant_q <= pick;
        is_wr_q <= h_wr[pick];
        addr_q  <= h_addr[64*int'(pick) +: 64] & ALIGN_MASK;
        wdata_q <= h_wdata[LINE_W*int'(pick) +: LINE_W];
      end
      if (state_q == RD && m_dv) rdata_q <= m_rdata;
    end
  end

  // A release takes effect one edge before any new owner can be chosen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_held  <= 1'b0;
      lock_owner <= '0;
    end else if (!lock_held) begin
      if (amo_any) begin
        lock_held  <= 1'b1;
        lock_owner <= amo_pick;
      end
    end else if (!h_amo_req[lock_owner]) begin
      lock_held <= 1'b0;
    end
  end

  always_comb begin
    h_dv      = '0;
    h_inv     = '0;
    h_amo_ack = '0;
    if (state_q == RESP) begin
      h_dv[grant_q] = 1'b1;
      if (is_wr_q) begin
        h_inv          = '1;
        h_inv[grant_q] = 1'b0;
      end
    end
    if (lock_held) h_amo_ack[lock_owner] = 1'b1;
  end

  assign m_rd       = (state_q == RD);
  assign m_wr       = (state_q == WR);
  assign m_addr     = addr_q;
  assign m_wdata    = wdata_q;
  assign h_inv_addr = addr_q;
  assign h_rdata    = rdata_q;

endmodule

// File: tb/tb_hbus_arb.sv
// Directed bench for hbus_arb (2 harts, 256-bit lines): read, write+invalidate,
// round-robin, AMO lock, rd+wr priority and asynchronous reset mid-transaction.
module tb_hbus_arb;

  localparam int N = 2;
  localparam int LW = 256;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*64-1:0] h_addr;
  logic [N*LW-1:0] h_wdata;
  logic [N-1:0]    h_rd, h_wr, h_dv, h_amo_req, h_amo_ack, h_inv;
  logic [LW-1:0]   h_rdata, m_wdata, m_rdata;
  logic [63:0]     h_inv_addr, m_addr;
  logic            m_rd, m_wr, m_dv;

  int checks = 0;
  int errors = 0;

  localparam logic [LW-1:0] PAT_A5 = {32{8'hA5}};
  localparam logic [LW-1:0] PAT_W1 = {16{16'h1111}};
  localparam logic [LW-1:0] PAT_W0 = {8{32'hC0DE_0000}};
  localparam logic [LW-1:0] PAT_R2 = {4{64'h0123_4567_89AB_CDEF}};
  localparam logic [LW-1:0] PAT_R3 = {32{8'h3C}};

  hbus_arb #(.N_HARTS(N), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .h_addr(h_addr), .h_wdata(h_wdata), .h_rd(h_rd), .h_wr(h_wr),
    .h_dv(h_dv), .h_rdata(h_rdata), .h_amo_req(h_amo_req), .h_amo_ack(h_amo_ack),
    .h_inv_addr(h_inv_addr), .h_inv(h_inv),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_rd(m_rd), .m_wr(m_wr),
    .m_rdata(m_rdata), .m_dv(m_dv)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_mem(input int budget, input string tag);
    int n = 0;
    while (!(m_rd || m_wr) && n < budget) begin
      step();
      n++;
    end
    check(tag, LW'(m_rd || m_wr), LW'(1));
  endtask

  // Pulse m_dv for one edge, landing in RESP.
  task automatic mem_done(input logic [LW-1:0] data);
    m_rdata = data;
    m_dv    = 1'b1;
    step();
    m_dv    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; h_addr = '0; h_wdata = '0; h_rd = '0; h_wr = '0;
    h_amo_req = '0; m_rdata = '0; m_dv = 1'b0;
    step(); step();
    check("rst_h_dv", LW'(h_dv), '0);
    check("rst_m_rdwr", LW'({m_rd, m_wr}), '0);
    check("rst_ack_inv", LW'({h_amo_ack, h_inv}), '0);
    check("rst_m_addr", LW'(m_addr), '0);
    check("rst_h_rdata", h_rdata, '0);
    rst = 1'b0;
    step();

    // Single read by hart0: aligned address, memory answers after two cycles.
    h_addr[63:0] = 64'h1234;
    h_rd = 2'b01;
    step();
    check("rd_m_rd", LW'(m_rd), LW'(1));
    check("rd_m_addr", LW'(m_addr), LW'(64'h1220));
    step();
    check("rd_m_rd_hold", LW'(m_rd), LW'(1));
    mem_done(PAT_A5);
    check("rd_h_dv", LW'(h_dv), LW'(2'b01));
    check("rd_h_rdata", h_rdata, PAT_A5);
    check("rd_h_inv", LW'(h_inv), '0);
    check("rd_m_rd_drop", LW'(m_rd), '0);
    h_rd = 2'b00;
    step();
    check("rd_h_dv_pulse", LW'(h_dv), '0);

    // Write by hart1 with invalidate to hart0.
    h_addr[127:64] = 64'h8040;
    h_wdata[2*LW-1:LW] = PAT_W1;
    h_wr = 2'b10;
    step();
    check("wr_m_wr", LW'({m_rd, m_wr}), LW'(2'b01));
    check("wr_m_addr", LW'(m_addr), LW'(64'h8040));
    check("wr_m_wdata", m_wdata, PAT_W1);
    mem_done('0);
    check("wr_h_dv", LW'(h_dv), LW'(2'b10));
    check("wr_h_inv", LW'(h_inv), LW'(2'b01));
    check("wr_inv_addr", LW'(h_inv_addr), LW'(64'h8040));
    check("wr_rdata_hold", h_rdata, PAT_A5);
    h_wr = 2'b00;
    step();
    check("wr_inv_pulse", LW'(h_inv), '0);

    // Round-robin: both harts read continuously; last grant was hart1.
    h_addr[63:0]   = 64'h100;
    h_addr[127:64] = 64'h200;
    h_rd = 2'b11;
    for (int t = 0; t < 4; t++) begin
      wait_mem(4, "rr_grant");
      check("rr_m_addr", LW'(m_addr), LW'((t % 2 == 0) ? 64'h100 : 64'h200));
      mem_done(LW'(t));
      check("rr_h_dv", LW'(h_dv), LW'((t % 2 == 0) ? 2'b01 : 2'b10));
      step();
    end
    h_rd = 2'b00;
    step();

    // AMO lock held by hart1 blocks hart0.
    h_amo_req = 2'b10;
    step();
    check("amo_ack", LW'(h_amo_ack), LW'(2'b10));
    h_rd = 2'b01;
    step(); step(); step();
    check("amo_block", LW'({m_rd, m_wr}), '0);
    h_addr[127:64] = 64'h300;
    h_rd = 2'b11;
    wait_mem(3, "amo_own_rd");
    check("amo_own_addr", LW'(m_addr), LW'(64'h300));
    mem_done(PAT_R3);
    check("amo_own_dv", LW'(h_dv), LW'(2'b10));
    h_rd = 2'b01;
    step();
    h_wr = 2'b10;
    wait_mem(3, "amo_own_wr");
    check("amo_own_is_wr", LW'(m_wr), LW'(1));
    mem_done('0);
    check("amo_wr_dv_inv", LW'({h_dv, h_inv}), LW'(4'b1001));
    h_wr = 2'b00;
    step();
    check("amo_still_block", LW'({m_rd, m_wr}), '0);
    h_amo_req = 2'b00;
    step();
    check("amo_release", LW'(h_amo_ack), '0);
    wait_mem(2, "amo_h0_grant");
    check("amo_h0_addr", LW'(m_addr), LW'(64'h100));
    mem_done(PAT_R3);
    check("amo_h0_dv", LW'(h_dv), LW'(2'b01));
    h_rd = 2'b00;
    step();

    // Simultaneous read and write from hart0: write first, read afterwards.
    h_addr[63:0] = 64'h400;
    h_wdata[LW-1:0] = PAT_W0;
    h_rd = 2'b01;
    h_wr = 2'b01;
    wait_mem(3, "both_first");
    check("both_wr_first", LW'({m_rd, m_wr}), LW'(2'b01));
    check("both_wdata", m_wdata, PAT_W0);
    mem_done('0);
    check("both_wr_dv_inv", LW'({h_dv, h_inv}), LW'(4'b0110));
    h_wr = 2'b00;
    step();
    wait_mem(3, "both_second");
    check("both_rd_second", LW'({m_rd, m_wr}), LW'(2'b10));
    mem_done(PAT_R2);
    check("both_rd_dv", LW'({h_dv, h_inv}), LW'(4'b0100));
    check("both_rdata", h_rdata, PAT_R2);
    h_rd = 2'b00;
    step();

    // Asynchronous reset in the middle of a read.
    h_addr[127:64] = 64'h500;
    h_rd = 2'b10;
    wait_mem(3, "arst_rd");
    #2;
    rst = 1'b1;
    #1;
    check("arst_m_rd", LW'({m_rd, m_wr}), '0);
    check("arst_m_addr", LW'(m_addr), '0);
    check("arst_rdata", h_rdata, '0);
    check("arst_dv_ack", LW'({h_dv, h_amo_ack, h_inv}), '0);
    h_rd = 2'b00;
    step();
    rst = 1'b0;
    mem_done(PAT_A5);
    check("arst_late_dv", LW'({h_dv, m_rd, m_wr}), '0);
    check("arst_late_rdata", h_rdata, '0);
    h_addr[63:0] = 64'h600;
    h_rd = 2'b01;
    wait_mem(3, "arst_new");
    check("arst_new_addr", LW'(m_addr), LW'(64'h600));
    mem_done(PAT_R3);
    check("arst_new_dv", LW'(h_dv), LW'(2'b01));
    check("arst_new_rdata", h_rdata, PAT_R3);
    h_rd = 2'b00;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
